// File: rtl/formula_sched_pkg.sv
// Shared types and helpers for the formula task scheduler.
// Slot state encoding, pool size limit and round-robin pointer step.
package formula_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } slot_state_t;

   localparam int MAX_WORKERS = 16;
   localparam int PTR_W       = $clog2(MAX_WORKERS);

   function automatic logic [PTR_W-1:0] ptr_next(
      input logic [PTR_W-1:0] ptr,
      input logic [PTR_W-1:0] last
   );
      return (ptr == last) ? '0 : ptr + PTR_W'(1);
   endfunction

endpackage

// File: rtl/formula_sched_slot.sv
// One scheduler slot: IDLE/BUSY/DONE tracking and the result buffer
// for a single attached worker; flags completions seen while not BUSY.
module formula_sched_slot
   import formula_sched_pkg::*;
#(
   parameter int W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        retire,
   input  logic        done,
   input  logic [W-1:0] done_res,
   output slot_state_t state,
   output logic [W-1:0] data,
   output logic        spurious
);

   slot_state_t state_nxt;
   logic        capture;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Result buffer, loaded only by a legitimate completion
   always_ff @(posedge clk) begin
      if (rst)          data <= '0;
      else if (capture) data <= done_res;
   end

   // Next state, capture enable and stray-completion flag
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      spurious  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = BUSY;
            spurious = done;
         end
         BUSY: begin
            if (done) begin
               state_nxt = DONE;
               capture   = 1'b1;
            end
         end
         DONE: begin
            if (retire) state_nxt = IDLE;
            spurious = done;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/formula_task_scheduler.sv
// In-order dispatcher of (a,b,c) triples onto a pool of formula workers.
// Optional perf counters: define FORMULA_SCHED_PERF_CNT_EN.
module formula_task_scheduler
   import formula_sched_pkg::*;
#(
   parameter int N_WORKERS = 4,
   parameter int W         = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arg_vld,
   output logic                   arg_rdy,
   input  logic [W-1:0]           a,
   input  logic [W-1:0]           b,
   input  logic [W-1:0]           c,
   output logic                   res_vld,
   input  logic                   res_rdy,
   output logic [W-1:0]           res,
   output logic [N_WORKERS-1:0]   wrk_arg_vld,
   output logic [W-1:0]           wrk_a,
   output logic [W-1:0]           wrk_b,
   output logic [W-1:0]           wrk_c,
   input  logic [N_WORKERS-1:0]   wrk_res_vld,
   input  logic [N_WORKERS*W-1:0] wrk_res,
   output logic                   err
`ifdef FORMULA_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]            perf_accepted,
   output logic [31:0]            perf_stall,
   output logic [31:0]            perf_bp
`endif
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(N_WORKERS - 1);

   slot_state_t            st   [N_WORKERS];
   logic [W-1:0]           sbuf [N_WORKERS];
   logic [N_WORKERS-1:0]   spurious;
   logic [N_WORKERS-1:0]   start;
   logic [N_WORKERS-1:0]   retire_sel;
   logic [PTR_W-1:0]       issue_ptr;
   logic [PTR_W-1:0]       retire_ptr;
   logic                   accept;
   logic                   retire;

   assign accept = arg_vld && arg_rdy;
   assign retire = res_vld && res_rdy;

   for (genvar i = 0; i < N_WORKERS; i++) begin : g_slot
      assign start[i]      = accept && (issue_ptr == PTR_W'(i));
      assign retire_sel[i] = retire && (retire_ptr == PTR_W'(i));

      formula_sched_slot #(
         .W (W)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .start    (start[i]),
         .retire   (retire_sel[i]),
         .done     (wrk_res_vld[i]),
         .done_res (wrk_res[i*W +: W]),
         .state    (st[i]),
         .data     (sbuf[i]),
         .spurious (spurious[i])
      );
   end

   // Registered-state views: issue slot readiness and retire slot output
   always_comb begin
      arg_rdy = 1'b0;
      res_vld = 1'b0;
      res     = '0;
      for (int i = 0; i < N_WORKERS; i++) begin
         if (issue_ptr == PTR_W'(i))
            arg_rdy = (st[i] == IDLE);
         if (retire_ptr == PTR_W'(i)) begin
            res_vld = (st[i] == DONE);
            res     = sbuf[i];
         end
      end
   end

   // Pointers, operand broadcast, start pulse and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_ptr   <= '0;
         retire_ptr  <= '0;
         wrk_arg_vld <= '0;
         wrk_a       <= '0;
         wrk_b       <= '0;
         wrk_c       <= '0;
         err         <= 1'b0;
      end else begin
         wrk_arg_vld <= start;
         if (accept) begin
            wrk_a     <= a;
            wrk_b     <= b;
            wrk_c     <= c;
            issue_ptr <= ptr_next(issue_ptr, LAST);
         end
         if (retire)
            retire_ptr <= ptr_next(retire_ptr, LAST);
         if (|spurious)
            err <= 1'b1;
      end
   end

`ifdef FORMULA_SCHED_PERF_CNT_EN
   // Saturating accept, producer-stall and consumer-backpressure counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_accepted <= '0;
         perf_stall    <= '0;
         perf_bp       <= '0;
      end else begin
         if (accept && (perf_accepted != '1))
            perf_accepted <= perf_accepted + 32'd1;
         if (arg_vld && !arg_rdy && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
         if (res_vld && !res_rdy && (perf_bp != '1))
            perf_bp <= perf_bp + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_formula_task_scheduler.sv
// Self-checking bench for formula_task_scheduler with 4 stub workers.
// Stubs compute a*b+c after a programmable latency; a queue model checks order.
module tb_formula_task_scheduler;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           arg_vld = 1'b0;
   logic           arg_rdy;
   logic [W-1:0]   a = '0, b = '0, c = '0;
   logic           res_vld;
   logic           res_rdy = 1'b1;
   logic [W-1:0]   res;
   logic [N-1:0]   wrk_arg_vld;
   logic [W-1:0]   wrk_a, wrk_b, wrk_c;
   logic [N-1:0]   wrk_res_vld;
   logic [N*W-1:0] wrk_res;
   logic           err;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;
   int n_ret  = 0;

   logic [W-1:0] exp_q [$];

   // stub workers
   logic [N-1:0] stub_vld = '0;
   logic [W-1:0] stub_res [N];
   int           cnt      [N];
   bit           act      [N];
   int           lat_cfg  [N];
   bit           lat_rand = 1'b0;
   logic [N-1:0] spur = '0;

   always #5 clk = ~clk;

   formula_task_scheduler #(
      .N_WORKERS (N),
      .W         (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .arg_vld     (arg_vld),
      .arg_rdy     (arg_rdy),
      .a           (a),
      .b           (b),
      .c           (c),
      .res_vld     (res_vld),
      .res_rdy     (res_rdy),
      .res         (res),
      .wrk_arg_vld (wrk_arg_vld),
      .wrk_a       (wrk_a),
      .wrk_b       (wrk_b),
      .wrk_c       (wrk_c),
      .wrk_res_vld (wrk_res_vld),
      .wrk_res     (wrk_res),
      .err         (err)
   );

   assign wrk_res_vld = stub_vld | spur;

   // pack stub results; a spurious pulse carries a poison value
   always_comb begin
      wrk_res = '0;
      for (int i = 0; i < N; i++)
         wrk_res[i*W +: W] = spur[i] ? 32'hDEAD_BEEF : stub_res[i];
   end

   // stub workers: see start at the edge, pulse L cycles after start pulse
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         stub_vld[i] <= 1'b0;
         if (rst) begin
            act[i] <= 1'b0;
         end else if (wrk_arg_vld[i]) begin
            act[i]      <= 1'b1;
            cnt[i]      <= (lat_rand ? $urandom_range(2, 30) : lat_cfg[i]) - 1;
            stub_res[i] <= wrk_a * wrk_b + wrk_c;
         end else if (act[i]) begin
            if (cnt[i] <= 1) begin
               stub_vld[i] <= 1'b1;
               act[i]      <= 1'b0;
            end else begin
               cnt[i] <= cnt[i] - 1;
            end
         end
      end
   end

   // reference model: acceptance-order queue of expected results
   always @(negedge clk) begin
      logic [W-1:0] exp_v;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (res_vld && res_rdy) begin
            checks++;
            n_ret++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL order: res=%h retired with nothing outstanding", res);
            end else begin
               exp_v = exp_q.pop_front();
               if (res !== exp_v) begin
                  errors++;
                  $display("FAIL result: got %h expected %h", res, exp_v);
               end
            end
         end
         if (arg_vld && arg_rdy) begin
            exp_q.push_back(a * b + c);
            n_acc++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b1; arg_vld = 1'b0; res_rdy = 1'b1; spur = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input int target, input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (n_ret >= target) break;
         @(posedge clk); #1;
      end
      if (n_ret >= target) ok = 1'b1;
   endtask

   task automatic test_reset;
      do_reset;
      checks++;
      if (arg_rdy !== 1'b1) begin errors++; $display("FAIL rst_arg_rdy: got %b expected 1", arg_rdy); end
      checks++;
      if (res_vld !== 1'b0) begin errors++; $display("FAIL rst_res_vld: got %b expected 0", res_vld); end
      checks++;
      if (res !== '0) begin errors++; $display("FAIL rst_res: got %h expected 0", res); end
      checks++;
      if (wrk_arg_vld !== '0) begin errors++; $display("FAIL rst_wrk_vld: got %b expected 0", wrk_arg_vld); end
      checks++;
      if ({wrk_a, wrk_b, wrk_c} !== '0) begin errors++; $display("FAIL rst_wrk_ops: got %h %h %h expected 0", wrk_a, wrk_b, wrk_c); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
   endtask

   task automatic test_single;
      int rise = -1;
      do_reset;
      for (int i = 0; i < N; i++) lat_cfg[i] = 5;
      arg_vld = 1'b1; a = 3; b = 4; c = 5;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      checks++;
      if (wrk_arg_vld !== 4'b0001) begin errors++; $display("FAIL single_start: got %b expected 0001", wrk_arg_vld); end
      checks++;
      if ({wrk_a, wrk_b, wrk_c} !== {32'd3, 32'd4, 32'd5}) begin errors++; $display("FAIL single_ops: got %0d %0d %0d expected 3 4 5", wrk_a, wrk_b, wrk_c); end
      for (int idx = 1; idx <= 20; idx++) begin
         if (idx > 1) begin @(posedge clk); #1; end
         if (res_vld && rise < 0) begin
            rise = idx;
            checks++;
            if (res !== 32'd17) begin errors++; $display("FAIL single_res: got %0d expected 17", res); end
         end
      end
      checks++;
      if (rise != 7) begin errors++; $display("FAIL single_latency: res_vld rose at %0d expected 7", rise); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
   endtask

   task automatic test_back_to_back;
      int sent = 0, acc0, ret0;
      bit took, ok;
      do_reset;
      for (int i = 0; i < N; i++) lat_cfg[i] = 10;
      acc0 = n_acc; ret0 = n_ret;
      arg_vld = 1'b1; a = $urandom; b = $urandom; c = $urandom;
      for (int cyc = 0; cyc < 2000 && sent < 20; cyc++) begin
         took = arg_rdy;
         @(posedge clk); #1;
         if (took) begin
            sent++;
            if (sent == 4) begin
               checks++;
               if (arg_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full: arg_rdy=%b expected 0 after 4 accepts", arg_rdy); end
            end
            a = $urandom; b = $urandom; c = $urandom;
         end
      end
      arg_vld = 1'b0;
      drain(ret0 + 20, 1000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_drain: retired %0d expected 20", n_ret - ret0); end
      checks++;
      if (n_acc - acc0 != 20) begin errors++; $display("FAIL b2b_accepted: got %0d expected 20", n_acc - acc0); end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: %0d outstanding expected 0", exp_q.size()); end
   endtask

   task automatic test_out_of_order;
      int ret0, i;
      bit ok, seen1 = 1'b0;
      do_reset;
      lat_cfg[0] = $urandom_range(15, 30);
      lat_cfg[1] = $urandom_range(2, 10);
      ret0 = n_ret;
      arg_vld = 1'b1; a = $urandom; b = $urandom; c = $urandom;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; c = $urandom;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      for (i = 0; i < 60; i++) begin
         if (stub_vld[1]) begin seen1 = 1'b1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!seen1) begin errors++; $display("FAIL ooo_w1: worker 1 never completed"); end
      @(posedge clk); #1;
      checks++;
      if (res_vld !== 1'b0) begin errors++; $display("FAIL ooo_hold: res_vld=%b expected 0 while worker 0 busy", res_vld); end
      checks++;
      if (n_ret != ret0) begin errors++; $display("FAIL ooo_early: retired %0d expected 0", n_ret - ret0); end
      drain(ret0 + 2, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ooo_drain: retired %0d expected 2", n_ret - ret0); end
   endtask

   task automatic test_backpressure;
      int sent = 0, acc0, ret0, bad = 0;
      bit took, ok;
      do_reset;
      for (int i = 0; i < N; i++) lat_cfg[i] = 3;
      acc0 = n_acc; ret0 = n_ret;
      res_rdy = 1'b0;
      arg_vld = 1'b1; a = $urandom; b = $urandom; c = $urandom;
      for (int cyc = 0; cyc < 50; cyc++) begin
         took = arg_vld && arg_rdy;
         @(posedge clk); #1;
         if (took) begin
            sent++;
            a = $urandom; b = $urandom; c = $urandom;
         end
         if (sent >= 4 && arg_rdy !== 1'b0) bad++;
      end
      checks++;
      if (sent != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL bp_rdy: arg_rdy high %0d cycles while full expected 0", bad); end
      checks++;
      if (res_vld !== 1'b1) begin errors++; $display("FAIL bp_res_vld: got %b expected 1", res_vld); end
      res_rdy = 1'b1;
      for (int cyc = 0; cyc < 200 && sent < 6; cyc++) begin
         took = arg_rdy;
         @(posedge clk); #1;
         if (took) begin
            sent++;
            a = $urandom; b = $urandom; c = $urandom;
         end
      end
      arg_vld = 1'b0;
      drain(ret0 + 6, 200, ok);
      checks++;
      if (!ok || n_acc - acc0 != 6) begin errors++; $display("FAIL bp_drain: accepted %0d retired %0d expected 6 6", n_acc - acc0, n_ret - ret0); end
   endtask

   task automatic test_random;
      int sent = 0, acc0, ret0;
      bit took, ok;
      do_reset;
      lat_rand = 1'b1;
      acc0 = n_acc; ret0 = n_ret;
      for (int cyc = 0; cyc < 4000 && sent < 30; cyc++) begin
         if (!arg_vld && $urandom_range(0, 2) != 0) begin
            arg_vld = 1'b1; a = $urandom; b = $urandom; c = $urandom;
         end
         res_rdy = ($urandom_range(0, 3) != 0);
         took = arg_vld && arg_rdy;
         @(posedge clk); #1;
         if (took) begin sent++; arg_vld = 1'b0; end
      end
      arg_vld = 1'b0;
      res_rdy = 1'b1;
      drain(ret0 + 30, 500, ok);
      lat_rand = 1'b0;
      checks++;
      if (!ok || n_acc - acc0 != 30) begin errors++; $display("FAIL rand_count: accepted %0d retired %0d expected 30 30", n_acc - acc0, n_ret - ret0); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rand_err: got %b expected 0", err); end
   endtask

   task automatic test_spurious;
      int ret0, sent = 0;
      bit took, ok;
      do_reset;
      for (int i = 0; i < N; i++) lat_cfg[i] = 4;
      spur = 4'b0100;
      @(posedge clk); #1;
      spur = '0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL spur_err: got %b expected 1", err); end
      checks++;
      if (res_vld !== 1'b0 || res !== '0) begin errors++; $display("FAIL spur_res: res_vld=%b res=%h expected 0 0", res_vld, res); end
      checks++;
      if (arg_rdy !== 1'b1) begin errors++; $display("FAIL spur_rdy: got %b expected 1", arg_rdy); end
      ret0 = n_ret;
      arg_vld = 1'b1; a = $urandom; b = $urandom; c = $urandom;
      for (int cyc = 0; cyc < 200 && sent < 6; cyc++) begin
         took = arg_rdy;
         @(posedge clk); #1;
         if (took) begin
            sent++;
            a = $urandom; b = $urandom; c = $urandom;
         end
      end
      arg_vld = 1'b0;
      drain(ret0 + 6, 200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL spur_flow: retired %0d expected 6", n_ret - ret0); end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %b expected 1", err); end
   endtask

   task automatic test_mid_reset;
      int ret0;
      bit ok;
      for (int i = 0; i < N; i++) lat_cfg[i] = 20;
      arg_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a = $urandom; b = $urandom; c = $urandom;
         @(posedge clk); #1;
      end
      arg_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (arg_rdy !== 1'b1 || res_vld !== 1'b0) begin errors++; $display("FAIL mrst_hs: arg_rdy=%b res_vld=%b expected 1 0", arg_rdy, res_vld); end
      checks++;
      if (wrk_arg_vld !== '0) begin errors++; $display("FAIL mrst_wrk: got %b expected 0", wrk_arg_vld); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b expected 0", err); end
      ret0 = n_ret;
      arg_vld = 1'b1; a = 7; b = 6; c = 1;
      @(posedge clk); #1;
      arg_vld = 1'b0;
      checks++;
      if (wrk_arg_vld !== 4'b0001) begin errors++; $display("FAIL mrst_issue: got %b expected 0001", wrk_arg_vld); end
      drain(ret0 + 1, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mrst_drain: retired %0d expected 1", n_ret - ret0); end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         lat_cfg[i]  = 5;
         stub_res[i] = '0;
         act[i]      = 1'b0;
         cnt[i]      = 0;
      end
      test_reset;
      test_single;
      test_back_to_back;
      test_out_of_order;
      test_backpressure;
      test_random;
      test_spurious;
      test_mid_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/formula_task_scheduler.md
# formula_task_scheduler

Dispatches (a, b, c) argument triples over a valid/ready interface to a small pool of N_WORKERS FSM-based formula units (formula_1_impl_1_top, formula_1_impl_2_top or formula_2_top) instantiated outside this block. Results are returned strictly in acceptance order. When every worker is occupied, the block stalls the producer, so a pool of 3–5 units replaces one instance per cycle of latency. It sits between the argument source and the worker pool in the formula pipelines.

## Interface
- N_WORKERS, 4, number of attached workers; legal range 1..16, power of two not required
- W, 32, operand/result width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- arg_vld  in  1  producer offers a triple
- arg_rdy  out  1  scheduler can accept a triple this cycle
- a, b, c  in  W each  operands
- res_vld  out  1  in-order result available
- res_rdy  in  1  consumer takes the result
- res  out  W  result data
- wrk_arg_vld  out  N_WORKERS  one-cycle start pulse, one bit per worker
- wrk_a, wrk_b, wrk_c  out  W each  registered operands, broadcast to all workers
- wrk_res_vld  in  N_WORKERS  worker completion pulse
- wrk_res  in  N_WORKERS*W  worker results; worker i occupies bits [i*W +: W]
- err  out  1  sticky: a completion pulse arrived from a worker that was not BUSY

## Operation
- Each slot i has a 2-bit state:
  - IDLE → BUSY on dispatch.
  - BUSY → DONE on wrk_res_vld[i]; wrk_res slice is captured into buf[i].
  - DONE → IDLE on retire.
- issue_ptr and retire_ptr count 0..N_WORKERS-1 and wrap to 0 after N_WORKERS-1.
- arg_rdy = (state[issue_ptr] == IDLE). It is derived only from registers; there is no combinational path from any input.
- Accept happens when arg_vld && arg_rdy:
  - wrk_a/b/c <= a/b/c.
  - wrk_arg_vld <= one-hot(issue_ptr) for exactly one cycle.
  - state[issue_ptr] <= BUSY.
  - issue_ptr advances.
- res_vld = (state[retire_ptr] == DONE); res = buf[retire_ptr].
- Retire happens when res_vld && res_rdy: the slot goes to IDLE and retire_ptr advances.
- Ordering: issue and retire both walk the same round-robin order, so output order equals acceptance order regardless of per-worker latency.
- A slot retiring in cycle T is not offered to the producer until T+1, because arg_rdy sees the registered IDLE state.
- wrk_res_vld[i] while slot i is IDLE or DONE: the pulse is ignored, buf[i] is unchanged, and err is set. err clears only on rst.
- Pipeline depth: at most N_WORKERS triples are in flight.

## Timing
- Reset values:
  - arg_rdy = 1.
  - res_vld = 0.
  - res = 0 (all buffers cleared).
  - wrk_arg_vld = 0; wrk_a/b/c = 0.
  - err = 0.
  - All slots IDLE; both pointers 0.
- rst mid-operation: all slots are abandoned and returned to IDLE. Workers are reset by the same rst, so their late pulses cannot occur.
- Cycle timing for a triple accepted at edge T with worker latency L (start pulse to res_vld):
  - wrk_arg_vld is high in cycle T+1.
  - The worker pulses in cycle T+1+L.
  - res_vld rises in cycle T+2+L, provided all older results have retired.
- Throughput: one triple per cycle while issue_ptr points at an IDLE slot. Sustained rate is min(1, N_WORKERS/(L+3)) with res_rdy held high.
- Simultaneous events are legal in one cycle:
  - accept on slot i
  - completion on slot j
  - retire on slot k
  Slots i, j and k are necessarily distinct.

## Configuration
- Macro FORMULA_SCHED_PERF_CNT_EN.
- Defined: adds three 32-bit saturating output counters, all cleared by rst:
  - perf_accepted: accepted triples.
  - perf_stall: cycles with arg_vld && !arg_rdy.
  - perf_bp: cycles with res_vld && !res_rdy.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Package formula_sched_pkg holds:
  - slot_state_t enum (IDLE, BUSY, DONE).
  - MAX_WORKERS = 16.
  - The pointer-increment-with-wrap function.
- Sub-module formula_sched_slot: one instance per worker. It contains the state register and buf[i], and reports the err contribution. The top level holds the pointers, operand registers and output mux.

## Test plan
- Single triple, N_WORKERS=4, stub latency L=5, a=3 b=4 c=5: wrk_arg_vld[0] pulses 1 cycle after accept; res_vld rises 7 cycles after accept; res equals stub output; err=0.
- 20 back-to-back triples, L=10, N_WORKERS=4, res_rdy=1: arg_rdy drops after the 4th accept. All 20 results emerge in order. Accepted count = 20 and no triple is duplicated.
- Per-worker random latencies 2..30: worker 1 finishes before worker 0. res is held until worker 0 completes, then both emerge in acceptance order.
- res_rdy=0 for 50 cycles with 6 offers: exactly 4 are accepted and arg_rdy stays 0. After releasing res_rdy, the 4 results drain in order and the remaining 2 triples are accepted.
- Spurious wrk_res_vld[2] with slot 2 IDLE: err=1 next cycle; buf and res_vld are unaffected; err stays 1 until rst.
- rst asserted with 3 triples in flight: the next cycle shows arg_rdy=1, res_vld=0, all wrk_arg_vld=0 and err=0. A new triple issues to worker 0.
